// File: rtl/sd_cmd_engine.sv
// SD command-line engine: serialises a 48-bit command frame with CRC7 on sd_cmd_o
// and captures an optional 48-bit response from sd_cmd_i, reporting status to the host.
module sd_cmd_engine #(
   parameter int CLK_HALF     = 63,
   parameter int RESP_TIMEOUT = 64
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic        cmd_start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic [1:0]  resp_type,
   output logic        busy,
   output logic        done,
   output logic [5:0]  resp_index,
   output logic [31:0] resp_arg,
   output logic        crc_err,
   output logic        timeout,
   output logic        sd_clk_o,
   output logic        sd_cmd_o,
   output logic        sd_cmd_oe,
   output logic        sd_cmd_dir,
   input  logic        sd_cmd_i
);

   localparam int DIV_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
   localparam int CNT_W = (RESP_TIMEOUT > 8) ? $clog2(RESP_TIMEOUT) : 3;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HALF - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RESP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] NCC_LAST = CNT_W'(7);

   typedef enum logic [2:0] {IDLE, WAITF, SEND, WAITR, RECV, NCC} state_t;

   state_t            state, state_n;
   logic [DIV_W-1:0]  div_cnt;
   logic [CNT_W-1:0]  cnt;
   logic [5:0]        bit_cnt;
   logic [5:0]        idx_lat;
   logic [31:0]       arg_lat;
   logic [1:0]        type_lat;
   logic [47:0]       tx_sr;
   logic [46:0]       rx_sr;
   logic [47:0]       rx_next;
   logic [47:0]       tx_frame;
   logic              tick, fall_tk, rise_tk, need_resp;

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   assign tick       = (div_cnt == DIV_LAST);
   assign fall_tk    = tick & sd_clk_o;
   assign rise_tk    = tick & ~sd_clk_o;
   assign need_resp  = (type_lat == 2'b01) || (type_lat == 2'b10);
   assign tx_frame   = {2'b01, idx_lat, arg_lat, crc7({2'b01, idx_lat, arg_lat}), 1'b1};
   assign rx_next    = {rx_sr, sd_cmd_i};
   assign sd_cmd_dir = sd_cmd_oe;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) state <= IDLE;
      else             state <= state_n;
   end

   // NOTE: every path assigns state_n after the default, so no latch is inferred.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (cmd_start) state_n = WAITF;
         WAITF: if (fall_tk) state_n = SEND;
         SEND:  if (fall_tk && bit_cnt == 6'd0) state_n = need_resp ? WAITR : NCC;
         WAITR: if (rise_tk) begin
                   // a start bit on the last counted edge still wins over the timeout
                   if (!sd_cmd_i)             state_n = RECV;
                   else if (cnt == TMO_LAST)  state_n = NCC;
                end
         RECV:  if (rise_tk && bit_cnt == 6'd0) state_n = NCC;
         NCC:   if (rise_tk && cnt == NCC_LAST) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         div_cnt    <= '0;
         sd_clk_o   <= 1'b0;
         cnt        <= '0;
         bit_cnt    <= '0;
         idx_lat    <= '0;
         arg_lat    <= '0;
         type_lat   <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         sd_cmd_o   <= 1'b1;
         sd_cmd_oe  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         resp_index <= '0;
         resp_arg   <= '0;
         crc_err    <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (tick) begin
            div_cnt  <= '0;
            sd_clk_o <= ~sd_clk_o;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         // shared edge counter restarts whenever the state changes
         if (state_n != state) cnt <= '0;
         else if (rise_tk)     cnt <= cnt + 1'b1;

         case (state)
            IDLE: if (cmd_start) begin
               idx_lat    <= cmd_index;
               arg_lat    <= cmd_arg;
               type_lat   <= resp_type;
               resp_index <= '0;
               resp_arg   <= '0;
               crc_err    <= 1'b0;
               timeout    <= 1'b0;
               busy       <= 1'b1;
            end
            WAITF: if (fall_tk) begin
               sd_cmd_o  <= tx_frame[47];
               sd_cmd_oe <= 1'b1;
               tx_sr     <= {tx_frame[46:0], 1'b1};
               bit_cnt   <= 6'd47;
            end
            SEND: if (fall_tk) begin
               if (bit_cnt != 6'd0) begin
                  sd_cmd_o <= tx_sr[47];
                  tx_sr    <= {tx_sr[46:0], 1'b1};
                  bit_cnt  <= bit_cnt - 1'b1;
               end else begin
                  sd_cmd_oe <= 1'b0;
                  sd_cmd_o  <= 1'b1;
               end
            end
            WAITR: if (rise_tk) begin
               if (!sd_cmd_i) begin
                  rx_sr   <= rx_next[46:0];
                  bit_cnt <= 6'd46;
               end else if (cnt == TMO_LAST) begin
                  timeout <= 1'b1;
               end
            end
            RECV: if (rise_tk) begin
               rx_sr <= rx_next[46:0];
               if (bit_cnt == 6'd0) begin
                  resp_index <= rx_next[45:40];
                  resp_arg   <= rx_next[39:8];
                  crc_err    <= ((type_lat == 2'b01) && (crc7(rx_next[47:8]) != rx_next[7:1]))
                                || !rx_next[0];
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            NCC: if (rise_tk && cnt == NCC_LAST) begin
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: captures transmitted frames, plays a card
// model's responses and checks status, timing and reset behaviour.
module tb_sd_cmd_engine;

   localparam int CH   = 4;
   localparam int BITP = 2 * CH;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic        cmd_start;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [1:0]  resp_type;
   logic        busy, done, crc_err, timeout;
   logic [5:0]  resp_index;
   logic [31:0] resp_arg;
   logic        sd_clk_o, sd_cmd_o, sd_cmd_oe, sd_cmd_dir;
   logic        sd_cmd_i;

   sd_cmd_engine #(.CLK_HALF(CH), .RESP_TIMEOUT(64)) dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .cmd_start   (cmd_start),
      .cmd_index   (cmd_index),
      .cmd_arg     (cmd_arg),
      .resp_type   (resp_type),
      .busy        (busy),
      .done        (done),
      .resp_index  (resp_index),
      .resp_arg    (resp_arg),
      .crc_err     (crc_err),
      .timeout     (timeout),
      .sd_clk_o    (sd_clk_o),
      .sd_cmd_o    (sd_cmd_o),
      .sd_cmd_oe   (sd_cmd_oe),
      .sd_cmd_dir  (sd_cmd_dir),
      .sd_cmd_i    (sd_cmd_i)
   );

   always #5 clk_clk = ~clk_clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   t0 = 0;
   int   first_lat = -1;
   int   cyc_done = 0;
   logic prev_sclk = 1'b0;
   bit   rose, fell;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_clk);
      cyc++;
      rose      = (sd_clk_o === 1'b1) && (prev_sclk === 1'b0);
      fell      = (sd_clk_o === 1'b0) && (prev_sclk === 1'b1);
      prev_sclk = sd_clk_o;
   endtask

   task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
      cmd_index = idx;
      cmd_arg   = arg;
      resp_type = rt;
      cmd_start = 1'b1;
      t0        = cyc;
      tick();
      cmd_start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic capture(input int nbits, input int pulse_at, output logic [47:0] fr);
      int nb = 0;
      int last_rise = -1;
      bit per_ok = 1'b1;
      first_lat = -1;
      fr = '0;
      for (int k = 0; k < 3000 && nb < nbits; k++) begin
         tick();
         cmd_start = 1'b0;
         if (sd_cmd_oe === 1'b1 && first_lat < 0) first_lat = cyc - t0;
         if (rose && sd_cmd_oe === 1'b1) begin
            fr = {fr[46:0], sd_cmd_o};
            if (last_rise >= 0 && (cyc - last_rise) != BITP) per_ok = 1'b0;
            last_rise = cyc;
            nb++;
            if (nb == pulse_at) begin
               cmd_start = 1'b1;
               check("busy_at_ignored_start", 64'(busy), 64'd1);
            end
         end
      end
      cmd_start = 1'b0;
      check("capture_bits", 64'(nb), 64'(nbits));
      check("sd_clk_period", 64'(per_ok), 64'd1);
   endtask

   task automatic wait_release();
      bit ok = 1'b0;
      for (int k = 0; k < 2 * BITP; k++) begin
         tick();
         if (sd_cmd_oe === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      check("release_after_frame", 64'(ok), 64'd1);
      check("idle_line_level", {62'd0, sd_cmd_o, sd_cmd_dir}, 64'b10);
   endtask

   task automatic wait_fall(output bit f);
      f = 1'b0;
      for (int k = 0; k < 4 * BITP; k++) begin
         tick();
         if (fell) begin
            f = 1'b1;
            break;
         end
      end
   endtask

   // card model: changes the line after each falling sd_clk, starting two clocks after release
   task automatic send_reply(input logic [47:0] r);
      bit ok = 1'b1;
      bit f;
      wait_fall(f); ok &= f;
      wait_fall(f); ok &= f;
      for (int i = 47; i >= 0; i--) begin
         sd_cmd_i = r[i];
         wait_fall(f);
         ok &= f;
      end
      sd_cmd_i = 1'b1;
      check("reply_clocked", 64'(ok), 64'd1);
   endtask

   task automatic wait_done(output int rises);
      rises = 0;
      for (int k = 0; k < 3000; k++) begin
         tick();
         if (rose) rises++;
         if (done === 1'b1) break;
      end
      cyc_done = cyc;
      check("done_seen", 64'(done), 64'd1);
      check("busy_low_with_done", 64'(busy), 64'd0);
      tick();
      check("done_single_cycle", 64'(done), 64'd0);
   endtask

   task automatic watch_quiet(input string tag, input int n);
      logic [2:0] seen = '0;
      for (int k = 0; k < n; k++) begin
         tick();
         seen |= {sd_cmd_oe, done, busy};
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   logic [47:0] fr;
   logic [47:0] pre;
   int          rises;
   int          dur;
   bit          f;

   initial begin
      reset_reset = 1'b1;
      cmd_start   = 1'b0;
      cmd_index   = '0;
      cmd_arg     = '0;
      resp_type   = '0;
      sd_cmd_i    = 1'b1;
      repeat (3) tick();
      check("rst_pins_flags", {56'd0, sd_clk_o, sd_cmd_o, sd_cmd_oe, sd_cmd_dir, busy, done, crc_err, timeout},
            64'b0100_0000);
      check("rst_resp", {26'd0, resp_index, resp_arg}, 64'd0);
      reset_reset = 1'b0;
      tick();

      // CMD0, no response; a stray start mid-frame must be ignored
      start_cmd(6'd0, 32'h0000_0000, 2'b00);
      capture(48, 10, fr);
      check("cmd0_frame", 64'(fr), 64'h4000_0000_0095);
      check("cmd0_first_bit_latency", 64'(first_lat >= 2 && first_lat <= 2 * CH + 1), 64'd1);
      wait_release();
      wait_done(rises);
      dur = cyc_done - t0;
      check("cmd0_ncc_rises", 64'(rises), 64'd8);
      check("cmd0_duration", 64'(dur >= 55 * BITP && dur <= 57 * BITP), 64'd1);
      check("cmd0_status", {62'd0, crc_err, timeout}, 64'd0);
      watch_quiet("cmd0_no_second_frame", 20 * BITP);

      // CMD8 with a valid R7 reply
      start_cmd(6'd8, 32'h0000_01AA, 2'b01);
      capture(48, 0, fr);
      check("cmd8_frame", 64'(fr), 64'h4800_0001_AA87);
      wait_release();
      send_reply(48'h08_0000_01AA_13);
      wait_done(rises);
      check("cmd8_ncc_rises", 64'(rises), 64'd8);
      check("cmd8_resp_index", 64'(resp_index), 64'd8);
      check("cmd8_resp_arg", 64'(resp_arg), 64'h0000_01AA);
      check("cmd8_status", {62'd0, crc_err, timeout}, 64'd0);

      // same, reply bit 20 flipped -> arg bit 12 flips, CRC fails
      start_cmd(6'd8, 32'h0000_01AA, 2'b01);
      capture(48, 0, fr);
      wait_release();
      send_reply(48'h08_0000_01AA_13 ^ (48'h1 << 20));
      wait_done(rises);
      check("flip_resp_arg", 64'(resp_arg), 64'h0000_11AA);
      check("flip_status", {62'd0, crc_err, timeout}, 64'b10);
      repeat (5 * BITP) tick();
      check("flip_status_held", {31'd0, crc_err, resp_arg}, {31'd0, 1'b1, 32'h0000_11AA});

      // ACMD41 with R3 reply: CRC field is all ones and must not be checked
      start_cmd(6'd41, 32'h40FF_8000, 2'b10);
      capture(48, 0, fr);
      wait_release();
      send_reply(48'h3F80_FF80_00FF);
      wait_done(rises);
      check("r3_resp_index", 64'(resp_index), 64'h3F);
      check("r3_resp_arg", 64'(resp_arg), 64'h80FF_8000);
      check("r3_crc_err", 64'(crc_err), 64'd0);

      // R3 reply with a bad end bit
      start_cmd(6'd41, 32'h40FF_8000, 2'b10);
      capture(48, 0, fr);
      wait_release();
      send_reply(48'h3F80_FF80_00FE);
      wait_done(rises);
      check("endbit_crc_err", 64'(crc_err), 64'd1);

      // silent card
      start_cmd(6'd8, 32'h0000_01AA, 2'b01);
      check("accept_clears_status", {25'd0, crc_err, timeout, resp_index, resp_arg}, 64'd0);
      capture(48, 0, fr);
      wait_release();
      wait_done(rises);
      check("tmo_rises", 64'(rises), 64'd72);
      check("tmo_status", {62'd0, crc_err, timeout}, 64'b01);
      check("tmo_resp_arg", 64'(resp_arg), 64'd0);

      // reset during bit 20 of the frame, with a stray start before it
      start_cmd(6'd17, 32'h1234_5678, 2'b00);
      capture(27, 5, fr);
      pre = {2'b01, 6'd17, 32'h1234_5678, 8'h00};
      check("abort_frame_prefix", 64'(fr[26:0]), 64'(pre[47:21]));
      wait_fall(f);
      check("abort_in_send", {62'd0, f, sd_cmd_oe}, 64'b11);
      reset_reset = 1'b1;
      tick();
      check("abort_pins_flags", {56'd0, sd_clk_o, sd_cmd_o, sd_cmd_oe, sd_cmd_dir, busy, done, crc_err, timeout},
            64'b0100_0000);
      check("abort_resp", {26'd0, resp_index, resp_arg}, 64'd0);
      reset_reset = 1'b0;
      watch_quiet("abort_no_activity", 30 * BITP);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Hardware SD-card command-line engine for the SD demonstration system. It replaces software bit-banging of the SD command pin through parallel I/O, and sits between the processor-facing control registers and the SD pads (clock, command and command-direction pins). It serialises a 48-bit command frame with generated CRC7 and captures the 48-bit response. It reports status: response index and argument, CRC/end-bit error, and timeout.

## Interface
Parameters:
- CLK_HALF, default 63: clk_clk cycles per sd_clk half-period. 50 MHz / 126 ≈ 397 kHz, the identification-mode rate.
- RESP_TIMEOUT, default 64: maximum sd_clk rising edges to wait for a response start bit (NCR).

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- cmd_start  in  1  single-cycle request; sampled only in IDLE
- cmd_index  in  6  command index
- cmd_arg  in  32  command argument
- resp_type  in  2  00 none; 01 48-bit with CRC check (R1/R6/R7); 10 48-bit without CRC check (R3); 11 treated as 00
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- resp_index  out  6  received index field
- resp_arg  out  32  received 32-bit payload
- crc_err  out  1  CRC7 mismatch (type 01 only) or end bit ≠ 1
- timeout  out  1  no start bit within RESP_TIMEOUT
- sd_clk_o  out  1  SD clock pin
- sd_cmd_o  out  1  command pin output value
- sd_cmd_oe  out  1  1 = engine drives the command pin
- sd_cmd_dir  out  1  level-shifter direction; always equal to sd_cmd_oe
- sd_cmd_i  in  1  command pin input, pre-synchronised

## Operation
- SD clock is free-running after reset; a divider toggles sd_clk_o every CLK_HALF cycles.
- Internal pulse fall_tk fires in the cycle sd_clk_o goes 1→0; rise_tk fires when it goes 0→1.
- Outputs change on fall_tk; sd_cmd_i is sampled on rise_tk.
- Transmit frame, MSB first: 0, 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], 1.
- CRC7 uses polynomial x^7+x^3+1 with initial value 0, computed over the first 40 bits.
- States:
  - IDLE: cmd_start=1 latches index, arg and type; clears resp_index, resp_arg, crc_err and timeout; busy←1; next state WAITF.
  - WAITF: wait for the next fall_tk; drive bit 47 with sd_cmd_oe=1; → SEND.
  - SEND: on each fall_tk, shift out the next bit. After bit 0 has been driven for one full sd_clk period, release the pin on fall_tk (sd_cmd_oe=0, sd_cmd_o=1). Then go to WAITR for types 01/10, otherwise to NCC.
  - WAITR: count rise_tk. sd_cmd_i=0 on a rise_tk → RECV, with bit 47 captured. After RESP_TIMEOUT rise_tk without a start bit → timeout←1, → NCC.
  - RECV: capture 47 further bits on rise_tk. After bit 0:
    - resp_index ← bits[45:40]
    - resp_arg ← bits[39:8]
    - crc_err ← (type 01 and CRC7 of bits[47:8] ≠ bits[7:1]) or bits[0]=0
    - → NCC
  - NCC: wait 8 rise_tk with the line released; done←1 for one cycle, busy←0; → IDLE.
- Transmission bit of the response (bit 46) is not checked.
- cmd_start while busy is ignored. resp_index, resp_arg, crc_err and timeout hold until the next accepted cmd_start.

## Timing
- Reset values: sd_clk_o=0, sd_cmd_o=1, sd_cmd_oe=0, sd_cmd_dir=0, busy=0, done=0, resp_index=0, resp_arg=0, crc_err=0, timeout=0. Divider is cleared; state is IDLE.
- Reset asserted mid-command aborts within the same edge: all outputs return to reset values, the pin is released, and no done pulse is issued.
- busy rises the cycle after the accepted cmd_start. It falls in the same cycle done is high.
- First frame bit appears on the first fall_tk after acceptance, i.e. at most 2·CLK_HALF+1 cycles later.
- Each frame bit is held for exactly 2·CLK_HALF cycles.
- Type 00 command duration: 48 bit periods plus 8 NCC periods, ±1 sd_clk period of alignment.
- Status outputs are valid in the cycle done=1 and remain valid afterwards.
- A start bit on the same rise_tk as the final timeout count is accepted as a start, not a timeout.

## Test plan
- CMD0, arg 0x00000000, type 00: captured frame is 0x400000000095, sd_cmd_oe low after the frame, done after 8 trailing clocks, crc_err=0, timeout=0.
- CMD8, arg 0x000001AA, type 01, model replies 0x080000 01AA13: transmitted frame is 0x48000001AA87; resp_index=8, resp_arg=0x000001AA, crc_err=0.
- Same as above, but the model flips response bit 20: crc_err=1, resp_arg reflects the flipped bit.
- ACMD41 reply with type 10, model sends 0x3F80FF8000FF: resp_arg=0x80FF8000, crc_err=0, CRC not checked.
- Type 01 with a silent card (sd_cmd_i=1): timeout=1 after 64 rise_tk; done follows 8 NCC clocks later; resp_arg=0.
- Reset pulsed during SEND bit 20, and cmd_start pulsed while busy: outputs return to reset values, the pin is released, and the ignored start produces no second frame.
